// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous reset, clear and count enable.
module hazard_sat_counter import hazard_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = '1;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall/flush event counters.
module hazard_ctrl import hazard_pkg::*; (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  freeze_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  ifid_uses_rt_i,
    input  logic                  idex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] idex_rt_i,
    input  logic                  branch_taken_i,
    input  logic                  cnt_clr_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  exmem_flush_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    state_t state;
    state_t next_state;
    logic   load_use;
    logic   stall_inc;
    logic   flush_inc;

    assign load_use = idex_mem_read_i && (idex_rt_i != '0) &&
                      ((idex_rt_i == ifid_rs_i) ||
                       (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Priority: reset, then freeze, then branch, then load-use.
    always_comb begin
        next_state    = state;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (rst_i) begin
            next_state    = RUN;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (freeze_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (branch_taken_i) begin
                        ifid_flush_o  = 1'b1;
                        idex_flush_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                        next_state    = FLUSH;
                        flush_inc     = 1'b1;
                    end else if (load_use && (state == RUN)) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                        next_state   = STALL;
                        stall_inc    = 1'b1;
                    end else begin
                        next_state = RUN;
                    end
                end
                FLUSH: begin
                    next_state = RUN;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    assign state_o = rst_i ? 2'(RUN) : 2'(state);

`ifdef HAZARD_PERF_CNT_EN
    logic cnt_clr;

    // A frozen pipeline holds its counters, including against a clear request.
    assign cnt_clr = cnt_clr_i && !freeze_i;

    hazard_sat_counter u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (cnt_clr),
        .en    (stall_inc),
        .count (stall_cnt_o)
    );

    hazard_sat_counter u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (cnt_clr),
        .en    (flush_inc),
        .count (flush_cnt_o)
    );
`else
    logic unused_cnt;

    assign unused_cnt  = cnt_clr_i ^ stall_inc ^ flush_inc;
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, freeze_i, ifid_uses_rt_i, idex_mem_read_i, branch_taken_i, cnt_clr_i;
    logic [4:0]  ifid_rs_i, ifid_rt_i, idex_rt_i;
    logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .freeze_i        (freeze_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .idex_mem_read_i (idex_mem_read_i),
        .idex_rt_i       (idex_rt_i),
        .branch_taken_i  (branch_taken_i),
        .cnt_clr_i       (cnt_clr_i),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_flush_o    (idex_flush_o),
        .exmem_flush_o   (exmem_flush_o),
        .state_o         (state_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst_i = 0; freeze_i = 0; branch_taken_i = 0; cnt_clr_i = 0;
        idex_mem_read_i = 0; idex_rt_i = 0; ifid_rs_i = 0; ifid_rt_i = 0; ifid_uses_rt_i = 0;
    endtask

    // One clock: predict outputs from the rules, compare, then advance the model.
    task automatic cycle();
        bit lu, go_flush, go_stall;
        int e_pc, e_fl_if, e_fl_id, e_fl_ex, e_state, nxt;
        #1;
        lu = idex_mem_read_i && (idex_rt_i != 0) &&
             ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
        go_flush = 0; go_stall = 0;
        e_state = m_state;
        if (rst_i) begin
            e_pc = 0; e_fl_if = 1; e_fl_id = 1; e_fl_ex = 1; e_state = 0; nxt = 0;
        end else if (freeze_i) begin
            e_pc = 0; e_fl_if = 0; e_fl_id = 0; e_fl_ex = 0; nxt = m_state;
        end else begin
            go_flush = (m_state != 2) && branch_taken_i;
            go_stall = (m_state == 0) && lu && !branch_taken_i;
            e_pc     = go_stall ? 0 : 1;
            e_fl_if  = go_flush ? 1 : 0;
            e_fl_ex  = go_flush ? 1 : 0;
            e_fl_id  = (go_flush || go_stall) ? 1 : 0;
            nxt      = go_flush ? 2 : (go_stall ? 1 : 0);
        end
        check("pc_write", 32'(pc_write_o), 32'(e_pc));
        check("ifid_write", 32'(ifid_write_o), 32'(e_pc));
        check("ifid_flush", 32'(ifid_flush_o), 32'(e_fl_if));
        check("idex_flush", 32'(idex_flush_o), 32'(e_fl_id));
        check("exmem_flush", 32'(exmem_flush_o), 32'(e_fl_ex));
        check("state", 32'(state_o), 32'(e_state));
        check("stall_cnt", 32'(stall_cnt_o), CNT_EN ? 32'(m_stall) : 32'd0);
        check("flush_cnt", 32'(flush_cnt_o), CNT_EN ? 32'(m_flush) : 32'd0);
        @(posedge clk_i);
        m_state = nxt;
        if (rst_i || (!freeze_i && cnt_clr_i)) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (go_stall && m_stall < 65535) m_stall++;
            if (go_flush && m_flush < 65535) m_flush++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        idle();
        rst_i = 1;
        cycle();
        cycle();
        idle();
        cycle();

        // Load-use on rs: one bubble then back to RUN.
        idex_mem_read_i = 1; idex_rt_i = 8; ifid_rs_i = 8;
        cycle();
        cycle();
        idle();
        cycle();

        // False hazards: $zero match, and rt match when rt is not read.
        idex_mem_read_i = 1; idex_rt_i = 0; ifid_rs_i = 0;
        cycle();
        idex_rt_i = 9; ifid_rs_i = 3; ifid_rt_i = 9; ifid_uses_rt_i = 0;
        cycle();
        ifid_uses_rt_i = 1;
        cycle();
        idle();
        cycle();

        // Branch together with a load-use hazard.
        idex_mem_read_i = 1; idex_rt_i = 5; ifid_rs_i = 5; branch_taken_i = 1;
        cycle();
        cycle();
        idle();
        cycle();

        // Freeze for three cycles while in STALL.
        idex_mem_read_i = 1; idex_rt_i = 7; ifid_rt_i = 7; ifid_uses_rt_i = 1;
        cycle();
        freeze_i = 1; branch_taken_i = 1; cnt_clr_i = 1;
        repeat (3) cycle();
        idle();
        cycle();
        cycle();

        // Reset in the middle of FLUSH.
        branch_taken_i = 1;
        cycle();
        idle();
        rst_i = 1;
        cycle();
        idle();
        cycle();

`ifdef HAZARD_PERF_CNT_EN
        // Saturation from a preloaded value, then clear beating a branch.
        force dut.u_flush_cnt.count = 16'hFFFE;
        #1;
        release dut.u_flush_cnt.count;
        m_flush = 65534;
        repeat (3) begin
            branch_taken_i = 1;
            cycle();
            idle();
            cycle();
        end
        check("flush_sat", 32'(flush_cnt_o), 32'hFFFF);
        branch_taken_i = 1; cnt_clr_i = 1;
        cycle();
        idle();
        cycle();
        check("flush_clr", 32'(flush_cnt_o), 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            rst_i           = ($urandom_range(0, 99) < 3);
            freeze_i        = ($urandom_range(0, 99) < 12);
            branch_taken_i  = ($urandom_range(0, 99) < 18);
            cnt_clr_i       = ($urandom_range(0, 99) < 4);
            idex_mem_read_i = ($urandom_range(0, 99) < 60);
            ifid_uses_rt_i  = 1'($urandom_range(0, 1));
            idex_rt_i       = 5'($urandom_range(0, 3));
            ifid_rs_i       = 5'($urandom_range(0, 3));
            ifid_rt_i       = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port freeze_i, input, 1 bit: external whole-pipeline hold (memory wait).
REQ-004 SHALL have ports ifid_rs_i and ifid_rt_i, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port ifid_uses_rt_i, input, 1 bit: the ID instruction reads rt as a source (R-type, beq, sw).
REQ-006 SHALL have ports idex_mem_read_i (1 bit) and idex_rt_i (5 bits), input: the ID/EX register's MEM_Read and rt outputs.
REQ-007 SHALL have port branch_taken_i, input, 1 bit: branch resolved taken in MEM (branch AND zero).
REQ-008 SHALL have ports pc_write_o and ifid_write_o, output, 1 bit each: load enables for PC and IF/ID.
REQ-009 SHALL have ports ifid_flush_o, idex_flush_o and exmem_flush_o, output, 1 bit each: zero that register's controls on the next edge.
REQ-010 SHALL have port state_o, output, 2 bits: current state (RUN=0, STALL=1, FLUSH=2).
REQ-011 SHALL have ports stall_cnt_o and flush_cnt_o, output, 16 bits each: event counters.
REQ-012 SHALL have port cnt_clr_i, input, 1 bit: synchronous clear of both counters.

Function
REQ-013 SHALL compute load_use = idex_mem_read_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)), combinationally.
REQ-014 SHALL drive all control outputs combinationally from the state and current inputs (zero-cycle latency); only the state and counters are registered.
REQ-015 SHALL, in RUN with branch_taken_i=1: assert all three flushes, set pc_write_o=1 and ifid_write_o=1, and next state FLUSH; branch beats load_use.
REQ-016 SHALL, in RUN with load_use=1 and no branch: set pc_write_o=0 and ifid_write_o=0, assert idex_flush_o (one bubble), and next state STALL.
REQ-017 SHALL, in RUN with neither event: set pc_write_o=1 and ifid_write_o=1 with all flushes at 0, and stay in RUN.
REQ-018 SHALL, in STALL: mask load_use, so that exactly one bubble is inserted per load, and return to RUN; a branch_taken_i in STALL SHALL be handled as in REQ-015.
REQ-019 SHALL, in FLUSH: ignore branch_taken_i and load_use, give normal enables with no flushes, and return to RUN.
REQ-020 SHALL, when freeze_i=1 outside reset: set pc_write_o=0, ifid_write_o=0 and all flushes 0; hold the state; hold the counters; freeze_i beats every other event.
REQ-021 SHALL increment stall_cnt_o on each RUN->STALL transition and flush_cnt_o on each transition into FLUSH; both saturate at 0xFFFF and never wrap.
REQ-022 SHALL zero both counters when cnt_clr_i=1; clear beats increment in the same cycle.

Reset
REQ-023 SHALL, on an edge with rst_i=1: set state to RUN and both counters to 0, overriding every other input, including mid-STALL or mid-FLUSH.
REQ-024 SHALL, while rst_i=1: drive pc_write_o=0, ifid_write_o=0, all three flushes=1 and state_o=0.

Configuration
REQ-025 SHALL compile the counters only when macro HAZARD_PERF_CNT_EN is defined; otherwise counter logic SHALL be absent, stall_cnt_o and flush_cnt_o SHALL read 0, cnt_clr_i SHALL be ignored, and the port list SHALL be unchanged.

Structure
REQ-026 SHALL take the state encoding, REG_ADDR_W=5 and CNT_W=16 from shared package hazard_pkg.
REQ-027 SHALL implement each counter as one instance of sub-module hazard_sat_counter (enable, clear, saturating).

Verification
REQ-028 SHALL cover a load-use stall: idex_mem_read_i=1, idex_rt_i=8, ifid_rs_i=8 in RUN -> pc_write_o=0, ifid_write_o=0, idex_flush_o=1, state STALL; next cycle RUN; stall_cnt_o=1.
REQ-029 SHALL cover a false hazard: idex_rt_i=0 matching ifid_rs_i=0, or rt match with ifid_uses_rt_i=0 -> no stall; state stays RUN.
REQ-030 SHALL cover simultaneous events: branch_taken_i=1 with load_use=1 -> three flushes, pc_write_o=1, state FLUSH, flush_cnt_o=1, stall_cnt_o unchanged.
REQ-031 SHALL cover freeze: freeze_i=1 for 3 cycles during STALL -> enables 0, no flushes, state_o stays 1, counters hold; STALL->RUN after release.
REQ-032 SHALL cover saturation and clear: preload flush_cnt_o=0xFFFE, apply two branches -> 0xFFFF; then cnt_clr_i together with a branch -> 0.
REQ-033 SHALL cover reset mid-FLUSH: rst_i=1 -> state_o=0, counters 0, flushes=1, pc_write_o=0.
